// File: rtl/rx_block_assembler_if.sv
// rx_block_assembler_if
//   Byte-in / block-out bundle for the receive-side block assembler.
//   slave  : seen by the assembler (bytes and ready in, block and status out)
//   master : seen by the producer/consumer side
//   rx_data/rx_valid  byte strobe from the UART receiver
//   block_ready       downstream accepts the held block
//   block_out/valid   assembled block, first byte in the top DATA_W bits
//   byte_count/busy   fill level, busy = fill level non-zero
//   timeout_err       one-cycle pulse, partial packet discarded
//   overrun_err       one-cycle pulse, byte dropped while block held
interface rx_block_assembler_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 16,
    parameter int CNT_W     = 5
);
    logic [DATA_W-1:0]           rx_data;
    logic                        rx_valid;
    logic                        block_ready;
    logic [DATA_W*NUM_BYTES-1:0] block_out;
    logic                        block_valid;
    logic [CNT_W-1:0]            byte_count;
    logic                        busy;
    logic                        timeout_err;
    logic                        overrun_err;

    modport slave (
        input  rx_data, rx_valid, block_ready,
        output block_out, block_valid, byte_count, busy, timeout_err, overrun_err
    );

    modport master (
        output rx_data, rx_valid, block_ready,
        input  block_out, block_valid, byte_count, busy, timeout_err, overrun_err
    );
endinterface

// File: rtl/rx_block_assembler.sv
// rx_block_assembler
//   Receive-side SIPO stage: shifts NUM_BYTES received bytes into one block,
//   holds the completed block until the downstream stage takes it, and
//   discards a partial packet after TIMEOUT_CYC idle cycles.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : rx_block_assembler_if.slave (byte input, block output, status)
module rx_block_assembler #(
    parameter int DATA_W      = 8,
    parameter int NUM_BYTES   = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 5
) (
    input logic                  clk,
    input logic                  reset,
    rx_block_assembler_if.slave  bus
);
    localparam int BLK_W = DATA_W * NUM_BYTES;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [BLK_W-1:0]   r_shift, w_shift_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [TO_W-1:0]    r_tcnt,  w_tcnt_nxt;
    logic               r_timeout_err, w_timeout_nxt;
    logic               r_overrun_err, w_overrun_nxt;
    logic [BLK_W-1:0]   w_shifted;

    assign w_shifted = {r_shift[BLK_W-DATA_W-1:0], bus.rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_count       <= '0;
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_count       <= w_count_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_timeout_err <= w_timeout_nxt;
            r_overrun_err <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_count_nxt   = r_count;
        w_tcnt_nxt    = '0;
        w_timeout_nxt = 1'b0;
        w_overrun_nxt = 1'b0;
        unique case (r_state)
            IDLE, COLLECT: begin
                if (bus.rx_valid) begin
                    w_shift_nxt = w_shifted;
                    w_count_nxt = r_count + 1'b1;
                    w_state_nxt = (r_count == CNT_W'(NUM_BYTES - 1)) ? FULL : COLLECT;
                end else if (r_state == COLLECT) begin
                    if (r_tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        w_shift_nxt   = '0;
                        w_count_nxt   = '0;
                        w_state_nxt   = IDLE;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.block_ready) begin
                    // Handoff frees the register this cycle, so a coincident
                    // byte becomes byte 1 of the next block instead of an overrun.
                    if (bus.rx_valid) begin
                        w_shift_nxt = w_shifted;
                        w_count_nxt = CNT_W'(1);
                        w_state_nxt = (NUM_BYTES == 1) ? FULL : COLLECT;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end else if (bus.rx_valid) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign bus.block_out   = r_shift;
    assign bus.block_valid = (r_state == FULL);
    assign bus.byte_count  = r_count;
    assign bus.busy        = (r_count != '0);
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun_err = r_overrun_err;
endmodule

// File: tb/tb_rx_block_assembler.sv
module tb_rx_block_assembler;
    localparam int NB  = 16;
    localparam int TCY = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_block_assembler_if #(.DATA_W(8), .NUM_BYTES(NB), .CNT_W(5)) bus ();

    rx_block_assembler #(
        .DATA_W(8), .NUM_BYTES(NB), .TIMEOUT_CYC(TCY), .CNT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bytes stored since the last clear, fill level, full flag,
    // idle-cycle count while partially filled.
    logic [7:0] m_hist[$];
    int         m_cnt;
    bit         m_full;
    int         m_idle;
    bit         m_to, m_ov;
    int         n_to_seen, n_ov_seen, n_valid_seen;

    function automatic logic [127:0] model_block();
        logic [127:0] b = '0;
        int k = m_hist.size();
        for (int i = 0; i < k; i++)
            b[8*(k-1-i) +: 8] = m_hist[i];
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input logic [7:0] d);
        m_hist.push_back(d);
        if (m_hist.size() > NB) void'(m_hist.pop_front());
    endtask

    task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit rdy);
        reset           = rst;
        bus.rx_valid    = v;
        bus.rx_data     = d;
        bus.block_ready = rdy;
        @(posedge clk);
        #1;
        m_to = 0;
        m_ov = 0;
        if (rst) begin
            m_hist.delete();
            m_cnt = 0; m_full = 0; m_idle = 0;
        end else if (m_full) begin
            m_idle = 0;
            if (rdy) begin
                m_full = 0;
                if (v) begin model_store(d); m_cnt = 1; end
                else m_cnt = 0;
            end else if (v) begin
                m_ov = 1;
            end
        end else if (v) begin
            model_store(d);
            m_cnt++;
            m_idle = 0;
            if (m_cnt == NB) m_full = 1;
        end else if (m_cnt > 0) begin
            m_idle++;
            if (m_idle == TCY) begin
                m_hist.delete();
                m_cnt = 0; m_idle = 0; m_to = 1;
            end
        end
        check("block_valid", 128'(bus.block_valid), 128'(m_full));
        check("byte_count",  128'(bus.byte_count),  128'(m_cnt));
        check("busy",        128'(bus.busy),        128'(m_cnt != 0));
        check("timeout_err", 128'(bus.timeout_err), 128'(m_to));
        check("overrun_err", 128'(bus.overrun_err), 128'(m_ov));
        check("block_out",   bus.block_out,         model_block());
        if (bus.timeout_err) n_to_seen++;
        if (bus.overrun_err) n_ov_seen++;
        if (bus.block_valid) n_valid_seen++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, rdy);
    endtask

    task automatic send_rand(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 8'($urandom), 0);
            if (max_gap > 0) idle($urandom_range(max_gap, 0), 0);
        end
    endtask

    initial begin
        m_cnt = 0; m_full = 0; m_idle = 0;
        // reset with inputs active: reset must dominate
        step(1, 1, 8'h55, 1);
        step(1, 0, 8'h00, 0);

        // first packet 0x00..0x0F
        for (int i = 0; i < NB; i++) step(0, 1, 8'(i), 0);
        check("pkt0_const", bus.block_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("pkt0_count", 128'(bus.byte_count), 128'd16);

        // hold, then hand off
        idle(20, 0);
        step(0, 0, 8'h00, 1);
        check("handoff_valid", 128'(bus.block_valid), 128'd0);

        // overrun then coincident handoff+store
        send_rand(NB, 0);
        step(0, 1, 8'hAA, 0);
        check("overrun_pulse", 128'(bus.overrun_err), 128'd1);
        step(0, 1, 8'hBB, 1);
        check("bb_lsb", 128'(bus.block_out[7:0]), 128'hBB);
        check("bb_count", 128'(bus.byte_count), 128'd1);

        // one-byte partial times out, then 5 bytes time out
        idle(10, 0);
        n_to_seen = 0;
        send_rand(5, 0);
        idle(12, 0);
        check("timeout_once", 128'(n_to_seen), 128'd1);

        for (int i = 0; i < NB; i++) step(0, 1, 8'(8'h10 + i), 0);
        check("pkt1_const", bus.block_out, 128'h101112131415161718191A1B1C1D1E1F);
        step(0, 0, 8'h00, 1);

        // rx_valid on the expiry cycle wins
        send_rand(3, 0);
        idle(TCY - 1, 0);
        step(0, 1, 8'h77, 0);
        check("expiry_byte_kept", 128'(bus.byte_count), 128'd4);
        idle(TCY + 2, 0);

        // reset with 9 bytes, reset while FULL, then a gapped packet
        send_rand(9, 0);
        step(1, 0, 8'h00, 0);
        send_rand(NB, 0);
        step(1, 1, 8'h12, 0);
        send_rand(NB, 3);
        step(0, 0, 8'h00, 1);

        // back-to-back streaming with ready held high
        n_to_seen = 0; n_ov_seen = 0; n_valid_seen = 0;
        for (int i = 0; i < 2 * NB; i++) step(0, 1, 8'($urandom), 1);
        check("b2b_blocks",  128'(n_valid_seen), 128'd2);
        check("b2b_overrun", 128'(n_ov_seen), 128'd0);
        check("b2b_timeout", 128'(n_to_seen), 128'd0);
        step(0, 0, 8'h00, 1);

        // random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom % 200) == 0, ($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
